// File: rtl/scan_code_output_fifo_pkg.sv
// Shared constants and helpers for the scan-code output path.
// Imported by the FIFO core and the top level.
package scan_code_pkg;

    localparam int SCAN_CODE_WIDTH = 8;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // All-ones value of an error counter of the given width (width <= 63).
    function automatic logic [63:0] err_cnt_sat(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/scan_code_output_fifo_sync_fifo_core.sv
// First-word-fall-through FIFO with a registered head output.
// Storage, pointers, level and full/empty for the scan-code buffer.
module sync_fifo_core
    import scan_code_pkg::*;
#(
    parameter int DATA_WIDTH = SCAN_CODE_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                          control_clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          valid,
    output logic                          full,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] head_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_nxt;
    logic [LW-1:0]         level_q;
    logic                  empty;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  load_wr;
    logic                  load_mem;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign rd_ok      = rd_en && !empty;
    assign wr_ok      = wr_en && (!full || rd_ok);
    assign rd_ptr_nxt = rd_ptr + PW'(1);

    // Head comes straight from the write port when the new code
    // becomes the only entry; otherwise from the slot behind it.
    assign load_wr  = wr_ok && (empty || (rd_ok && level_q == LW'(1)));
    assign load_mem = rd_ok && (level_q > LW'(1));

    always_ff @(posedge control_clock) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge control_clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            unique case (1'b1)
                load_wr:  head_q <= wr_data;
                load_mem: head_q <= mem[rd_ptr_nxt];
                default:  head_q <= head_q;
            endcase
        end
    end

    assign rd_data = head_q;
    assign valid   = !empty;
    assign level   = level_q;

endmodule

// File: rtl/scan_code_output_fifo.sv
// Buffers parity-checked scan codes for the host interface and
// tracks dropped codes and parity errors.
module scan_code_output_fifo
    import scan_code_pkg::*;
#(
    parameter int DATA_WIDTH    = SCAN_CODE_WIDTH,
    parameter int DEPTH         = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                          control_clock,
    input  logic                          reset,
    input  logic                          strobe_detected,
    input  logic                          parity_detected,
    input  logic [DATA_WIDTH-1:0]         scan_code_for_buffering,
    output logic [DATA_WIDTH-1:0]         interface_data_out,
    output logic                          interface_data_valid,
    input  logic                          interface_data_ready,
    output logic [level_width(DEPTH)-1:0] fifo_level,
    output logic                          overflow_flag,
    output logic [ERR_CNT_WIDTH-1:0]      parity_error_count,
    input  logic                          clear_errors
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_SAT =
        ERR_CNT_WIDTH'(err_cnt_sat(ERR_CNT_WIDTH));

    logic push_req;
    logic bad_parity;
    logic pop;
    logic full;
    logic overflow_evt;

    assign push_req     = strobe_detected && parity_detected;
    assign bad_parity   = strobe_detected && !parity_detected;
    assign pop          = interface_data_valid && interface_data_ready;
    assign overflow_evt = push_req && full && !pop;

    sync_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .control_clock (control_clock),
        .reset         (reset),
        .wr_en         (push_req),
        .wr_data       (scan_code_for_buffering),
        .rd_en         (interface_data_ready),
        .rd_data       (interface_data_out),
        .valid         (interface_data_valid),
        .full          (full),
        .level         (fifo_level)
    );

    // A clear still records an event that lands in the same cycle.
    always_ff @(posedge control_clock) begin
        if (reset) begin
            overflow_flag      <= 1'b0;
            parity_error_count <= '0;
        end else if (clear_errors) begin
            overflow_flag      <= overflow_evt;
            parity_error_count <= ERR_CNT_WIDTH'(bad_parity);
        end else begin
            if (overflow_evt) begin
                overflow_flag <= 1'b1;
            end
            if (bad_parity && parity_error_count != ERR_SAT) begin
                parity_error_count <= parity_error_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_code_output_fifo.sv
// Randomised scoreboard bench for scan_code_output_fifo.
// A queue-based reference model predicts every output.
module tb_scan_code_output_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          stb;
    logic          par;
    logic [DW-1:0] code;
    logic          rdy;
    logic          clr;

    logic [DW-1:0] data_out;
    logic          valid;
    logic [LW-1:0] level;
    logic          ovf;
    logic [7:0]    cnt8;

    logic [DW-1:0] data_out2;
    logic          valid2;
    logic [LW-1:0] level2;
    logic          ovf2;
    logic [1:0]    cnt2;

    scan_code_output_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ERR_CNT_WIDTH(8)
    ) dut (
        .control_clock           (clk),
        .reset                   (reset),
        .strobe_detected         (stb),
        .parity_detected         (par),
        .scan_code_for_buffering (code),
        .interface_data_out      (data_out),
        .interface_data_valid    (valid),
        .interface_data_ready    (rdy),
        .fifo_level              (level),
        .overflow_flag           (ovf),
        .parity_error_count      (cnt8),
        .clear_errors            (clr)
    );

    scan_code_output_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ERR_CNT_WIDTH(2)
    ) dut2 (
        .control_clock           (clk),
        .reset                   (reset),
        .strobe_detected         (stb),
        .parity_detected         (par),
        .scan_code_for_buffering (code),
        .interface_data_out      (data_out2),
        .interface_data_valid    (valid2),
        .interface_data_ready    (rdy),
        .fifo_level              (level2),
        .overflow_flag           (ovf2),
        .parity_error_count      (cnt2),
        .clear_errors            (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    bit started = 1'b0;

    // Reference model state: stored codes, last popped code, error state.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_last = '0;
    bit            m_ovf  = 1'b0;
    int            m_cnt8 = 0;
    int            m_cnt2 = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic model_update();
        bit pop, preq, bad, evt;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_last = '0;
            m_ovf  = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
            return;
        end
        pop  = rdy && (mq.size() > 0);
        preq = stb && par;
        bad  = stb && !par;
        evt  = preq && (mq.size() == DEPTH) && !pop;
        if (pop) m_last = mq.pop_front();
        if (preq && !evt) begin
            mq.push_back(code);
            exp_q.push_back(code);
        end
        if (clr) begin
            m_ovf  = evt;
            m_cnt8 = bad ? 1 : 0;
            m_cnt2 = bad ? 1 : 0;
        end else begin
            if (evt) m_ovf = 1'b1;
            if (bad && m_cnt8 < 255) m_cnt8++;
            if (bad && m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic p,
                        input logic [DW-1:0] c, input logic rd,
                        input logic cl);
        reset = r; stb = s; par = p; code = c; rdy = rd; clr = cl;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Monitor: mid-cycle compare against the model; a handshake seen
    // here completes on the coming edge, so the head is scored now.
    always @(negedge clk) begin
        logic [DW-1:0] m_out;
        if (started) begin
            m_out = (mq.size() > 0) ? mq[0] : m_last;
            chk("level", level, mq.size());
            chk("valid", valid, mq.size() > 0);
            chk("data_out", data_out, m_out);
            chk("overflow", ovf, m_ovf);
            chk("err_cnt8", cnt8, m_cnt8);
            chk("err_cnt2", cnt2, m_cnt2);
            if (valid && rdy && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("pop_data", data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int bias;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        started = 1'b1;

        // single good code
        step(0, 1, 1, 8'h1C, 0, 0);
        chk("first_valid", valid, 1);
        chk("first_data", data_out, 8'h1C);
        chk("first_level", level, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("hold_last", data_out, 8'h1C);

        // overflow on fifth push, then drain in order
        step(0, 1, 1, 8'h11, 0, 0);
        step(0, 1, 1, 8'h22, 0, 0);
        step(0, 1, 1, 8'h33, 0, 0);
        step(0, 1, 1, 8'h44, 0, 0);
        step(0, 1, 1, 8'h55, 0, 0);
        chk("ovf_level", level, 4);
        chk("ovf_flag", ovf, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        chk("drained_valid", valid, 0);
        chk("drained_data", data_out, 8'h44);

        // parity errors and clear with coincident error
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 8'hAA, 0, 0);
        step(0, 1, 0, 8'hAA, 0, 0);
        step(0, 1, 0, 8'hAA, 0, 0);
        chk("perr_3", cnt8, 3);
        step(0, 1, 0, 8'hAA, 0, 1);
        chk("perr_clr", cnt8, 1);
        chk("perr_level", level, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 0, 0);
        chk("sat_cnt2", cnt2, 3);
        chk("cnt8_6", cnt8, 6);

        // full FIFO with simultaneous push and pop
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 8'hA1, 0, 0);
        step(0, 1, 1, 8'hA2, 0, 0);
        step(0, 1, 1, 8'hA3, 0, 0);
        step(0, 1, 1, 8'hA4, 0, 0);
        step(0, 1, 1, 8'hA5, 1, 0);
        chk("fullpp_level", level, 4);
        chk("fullpp_ovf", ovf, 0);
        chk("fullpp_head", data_out, 8'hA2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        chk("fullpp_tail", data_out, 8'hA5);

        // reset with a push in flight
        step(0, 1, 1, 8'hB1, 0, 0);
        step(0, 1, 1, 8'hB2, 0, 0);
        step(0, 1, 1, 8'hB3, 0, 0);
        step(1, 1, 1, 8'hB4, 1, 0);
        chk("rst_level", level, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);

        // randomised traffic with varying consumer pressure
        bias = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) bias = $urandom_range(0, 3);
            step(($urandom_range(0, 249) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 2) < bias),
                 ($urandom_range(0, 39) == 0));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_code_output_fifo.md
# scan_code_output_fifo

Parametrised successor to the single-byte scan-code output register. It sits between the PS/2 frame decoder and the host-facing interface. A decoded scan code is accepted only when its strobe and parity checks both pass, and accepted codes are buffered in a DEPTH-entry first-word-fall-through FIFO. The downstream side reads through a valid/ready handshake. The block also reports FIFO fill level, a sticky overflow flag and a saturating parity-error counter.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one scan code.
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- ERR_CNT_WIDTH, 8, width of the parity-error counter.

Ports:
- control_clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; one clock and synchronous active-high reset, as already decided.
- strobe_detected  in  1  a decoded frame is present this cycle (single-cycle pulse).
- parity_detected  in  1  the frame's parity check passed; sampled only when strobe_detected=1.
- scan_code_for_buffering  in  DATA_WIDTH  decoded code; sampled only when strobe_detected=1.
- interface_data_out  out  DATA_WIDTH  head-of-FIFO code.
- interface_data_valid  out  1  FIFO is non-empty and interface_data_out is meaningful.
- interface_data_ready  in  1  consumer accepts the head this cycle.
- fifo_level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow_flag  out  1  sticky; a good code was dropped because the FIFO was full.
- parity_error_count  out  ERR_CNT_WIDTH  saturating count of strobes with bad parity.
- clear_errors  in  1  synchronous clear of overflow_flag and parity_error_count.

## Operation
- Push request: strobe_detected && parity_detected.
- Pop: interface_data_valid && interface_data_ready.
- Push accepted when not full, or when full with a pop in the same cycle; level unchanged in the full-with-pop case.
- Push while full with no pop: the code is discarded, FIFO contents are untouched, and overflow_flag is set.
- strobe_detected && !parity_detected: no push; parity_error_count increments and saturates at all-ones. scan_code_for_buffering is ignored.
- strobe_detected=0: parity_detected and data are don't-care.
- Ordering is strict FIFO. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from fifo_level.
- interface_data_out always shows the head entry. When the FIFO is empty it holds the last popped value (0 after reset). Consumers must qualify it with valid.
- Behaviour while valid=0: interface_data_ready has no effect.
- clear_errors takes priority for the bits it clears, but a same-cycle event is still recorded: counter becomes 1 if a parity error coincides, and overflow_flag becomes 1 if an overflow coincides.
- Reset values: interface_data_out=0, interface_data_valid=0, fifo_level=0, overflow_flag=0, parity_error_count=0, pointers=0.
- Reset mid-operation discards all entries, and any push or pop in the reset cycle is ignored.

## Timing
- Push at edge N: entry counted in fifo_level after N. If the FIFO was empty, interface_data_valid=1 and the code appears on interface_data_out after N (1-cycle latency).
- Pop at edge N: the next entry, if any, is presented after N. With zero remaining entries, valid falls after N.
- Back-to-back pushes every cycle and pops every cycle are sustained with no bubbles.
- Simultaneous push and pop when level=1: after the edge, level stays 1 and the pushed code is at the head.
- Error outputs update on the edge following the causing strobe.
- No combinational path from interface_data_ready to any output.

## Structure
- Package scan_code_pkg holds:
  - the default scan-code width constant (8);
  - a level-width function ($clog2(DEPTH)+1);
  - the error-counter saturation value.
- One sub-module, sync_fifo_core, implements storage, pointers, level and full/empty. It is parametrised by DATA_WIDTH and DEPTH.
- The top level holds accept/reject qualification, the overflow flag and the error counter.

## Test plan
- Reset, then single strobe with good parity and code 8'h1C, ready=0 → valid=1, data_out=8'h1C and level=1 one cycle later; overflow_flag=0, parity_error_count=0.
- DEPTH=4, push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with ready=0 → level=4 and overflow_flag=1. Then ready=1 → reads 11, 22, 33, 44 in order; 8'h55 never appears; valid falls after the 4th pop.
- Three strobes with parity_detected=0, then clear_errors coincident with a 4th bad strobe → count 1, 2, 3, then 1; level stays 0.
- ERR_CNT_WIDTH=2 with 5 bad-parity strobes → count saturates at 3.
- Full FIFO with push and pop in the same cycle → level stays 4, no overflow, and the pushed code emerges after the three older entries.
- Reset asserted while level=3 and a push is in flight → level=0, valid=0, data_out=0 next cycle; the in-flight code is not stored.
